// File: rtl/video_tg_ilace.sv
// Interlace/progressive NTSC-style timing generator.
// Counts pixels, lines, fields and frames, and produces registered blanking,
// composite sync (with equalising and serration pulses in the vertical block),
// burst gate and a frame-start strobe.
module video_tg_ilace #(
    parameter int C_H_W          = 10,
    parameter int C_V_W          = 9,
    parameter int C_H_PX_N       = 780,
    parameter int C_H_ACT_PX_N   = 640,
    parameter int C_HS_START     = 659,
    parameter int C_H_SYNC_N     = 58,
    parameter int C_EQ_N         = 29,
    parameter int C_SERR_N       = 58,
    parameter int C_BURST_OFS_N  = 64,
    parameter int C_BURST_N      = 31,
    parameter int C_V_LINE_N     = 263,
    parameter int C_V_ACT_LINE_N = 240,
    parameter int C_V_SYNC_OFS_N = 1
) (
    input  logic             CK_i,
    input  logic             ARST_i,
    input  logic             CK_EE_i,
    input  logic             RST_i,
    input  logic             INTERLACE_i,
    input  logic             BURST_EN_i,
    output logic [C_H_W-1:0] HCTRs_o,
    output logic [C_V_W-1:0] VCTRs_o,
    output logic [7:0]       FCTRs_o,
    output logic             FIELD_o,
    output logic             XBLK_o,
    output logic             XSYNC_o,
    output logic             BURST_o,
    output logic             FRAME_START_o
);

    localparam int H_HALF    = C_H_PX_N / 2;
    localparam int P0        = C_HS_START;
    localparam int P1        = (C_HS_START + H_HALF) % C_H_PX_N;
    localparam int VS_LINE   = C_V_ACT_LINE_N + C_V_SYNC_OFS_N;
    localparam int SERR_LOW  = H_HALF - C_SERR_N;
    localparam int BURST_BEG = (P0 + C_BURST_OFS_N) % C_H_PX_N;

    // Distance from pulse point p forward to h, modulo one line.
    function automatic int hdist(input int h, input int p);
        int r;
        r = (h >= p) ? (h - p) : (h + C_H_PX_N - p);
        return r;
    endfunction

    // Low width of the pulse launched on line line_s at P0 (at_p1=0) or P1.
    // Inside the vertical block the half-line slot index k selects an
    // equalising or serration pulse; outside, only P0 carries line sync.
    function automatic int pulse_w(input int line_s, input logic at_p1, input logic fld);
        int rel;
        int k;
        int w;
        if (!fld) begin
            rel = line_s - VS_LINE;
            k   = at_p1 ? (2 * rel - 1) : (2 * rel);
        end else begin
            rel = line_s - VS_LINE - 1;
            k   = at_p1 ? (2 * rel) : (2 * rel + 1);
        end
        if (k >= 0 && k <= 17) begin
            w = (k < 6 || k > 11) ? C_EQ_N : SERR_LOW;
        end else begin
            w = at_p1 ? 0 : C_H_SYNC_N;
        end
        return w;
    endfunction

    // True while a pulse launched at point p is still low at (h, v).  A pulse
    // seen at h < p belongs to the previous line and has wrapped past HCTR=0.
    function automatic logic sync_low(input int h, input int v, input int p,
                                      input logic at_p1, input logic fld);
        logic started;
        int   line_s;
        started = (h >= p) || (v > 0);
        line_s  = (h >= p) ? v : (v - 1);
        return started && (hdist(h, p) < pulse_w(line_s, at_p1, fld));
    endfunction

    logic [C_H_W-1:0] hctr_q, hctr_d;
    logic [C_V_W-1:0] vctr_q, vctr_d;
    logic [7:0]       fctr_q, fctr_d;
    logic             field_q, field_d;
    logic             mode_q, mode_d;
    logic             xblk_q, xblk_d;
    logic             xsync_q, xsync_d;
    logic             burst_q, burst_d;
    logic             fs_q, fs_d;

    logic             h_wrap;
    logic             field_end;
    logic             frame_end;
    logic [C_V_W-1:0] last_line;
    int               h_i;
    int               v_i;

    // Decode of the current position into next blank/sync/burst levels.
    always_comb begin
        h_i     = int'(hctr_q);
        v_i     = int'(vctr_q);
        xblk_d  = (h_i < C_H_ACT_PX_N) && (v_i < C_V_ACT_LINE_N);
        xsync_d = !(sync_low(h_i, v_i, P0, 1'b0, field_q) ||
                    sync_low(h_i, v_i, P1, 1'b1, field_q));
        burst_d = BURST_EN_i && (hdist(h_i, BURST_BEG) < C_BURST_N) &&
                  !(v_i >= VS_LINE && v_i <= VS_LINE + 9);
    end

    // Line, field and frame boundary detection.
    always_comb begin
        h_wrap    = (hctr_q == C_H_W'(C_H_PX_N - 1));
        last_line = (mode_q && field_q) ? C_V_W'(C_V_LINE_N - 2) : C_V_W'(C_V_LINE_N - 1);
        field_end = h_wrap && (vctr_q == last_line);
        frame_end = field_end && (!mode_q || field_q);
    end

    // Next-state for counters, mode and strobe; sync reset beats the enable.
    always_comb begin
        hctr_d  = hctr_q;
        vctr_d  = vctr_q;
        fctr_d  = fctr_q;
        field_d = field_q;
        mode_d  = mode_q;
        fs_d    = fs_q;
        if (RST_i) begin
            hctr_d  = '0;
            vctr_d  = '0;
            fctr_d  = '0;
            field_d = 1'b0;
            mode_d  = 1'b0;
            fs_d    = 1'b0;
        end else if (CK_EE_i) begin
            hctr_d = h_wrap ? '0 : hctr_q + C_H_W'(1);
            if (field_end) begin
                vctr_d = '0;
            end else if (h_wrap) begin
                vctr_d = vctr_q + C_V_W'(1);
            end
            if (field_end && mode_q) begin
                field_d = !field_q;
            end
            if (frame_end) begin
                fctr_d = fctr_q + 8'd1;
                mode_d = INTERLACE_i;
            end
            fs_d = frame_end;
        end
    end

    // State and output registers; outputs only move on enabled cycles.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            hctr_q  <= '0;
            vctr_q  <= '0;
            fctr_q  <= '0;
            field_q <= 1'b0;
            mode_q  <= 1'b0;
            xblk_q  <= 1'b0;
            xsync_q <= 1'b1;
            burst_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hctr_q  <= hctr_d;
            vctr_q  <= vctr_d;
            fctr_q  <= fctr_d;
            field_q <= field_d;
            mode_q  <= mode_d;
            fs_q    <= fs_d;
            if (RST_i) begin
                xblk_q  <= 1'b0;
                xsync_q <= 1'b1;
                burst_q <= 1'b0;
            end else if (CK_EE_i) begin
                xblk_q  <= xblk_d;
                xsync_q <= xsync_d;
                burst_q <= burst_d;
            end
        end
    end

    assign HCTRs_o       = hctr_q;
    assign VCTRs_o       = vctr_q;
    assign FCTRs_o       = fctr_q;
    assign FIELD_o       = field_q;
    assign XBLK_o        = xblk_q;
    assign XSYNC_o       = xsync_q;
    assign BURST_o       = burst_q;
    assign FRAME_START_o = fs_q;

endmodule

// File: tb/tb_video_tg_ilace.sv
// Bench for video_tg_ilace with a shrunken raster so several frames fit in a
// short run.  Expected waveforms are painted from the pulse/slot rules into
// per-field maps; a scoreboard queue decouples the driver from the monitor.
module tb_video_tg_ilace;

    localparam int HW    = 7;
    localparam int VW    = 6;
    localparam int N     = 80;
    localparam int ACT   = 60;
    localparam int HS    = 66;
    localparam int HSYNC = 6;
    localparam int EQ    = 3;
    localparam int SERR  = 6;
    localparam int BOFS  = 8;
    localparam int BN    = 10;
    localparam int VL    = 21;
    localparam int VACT  = 8;
    localparam int VOFS  = 1;

    localparam int VS    = VACT + VOFS;
    localparam int P0    = HS;
    localparam int P1    = (HS + N / 2) % N;
    localparam int SLOW  = N / 2 - SERR;
    localparam int BST   = (P0 + BOFS) % N;
    localparam int FLEN  = VL * N;

    logic          clk = 1'b0;
    logic          arst, rst, ee, ilace, ben;
    logic [HW-1:0] hctr;
    logic [VW-1:0] vctr;
    logic [7:0]    fctr;
    logic          field, xblk, xsync, burst, fstart;

    video_tg_ilace #(
        .C_H_W(HW), .C_V_W(VW), .C_H_PX_N(N), .C_H_ACT_PX_N(ACT),
        .C_HS_START(HS), .C_H_SYNC_N(HSYNC), .C_EQ_N(EQ), .C_SERR_N(SERR),
        .C_BURST_OFS_N(BOFS), .C_BURST_N(BN), .C_V_LINE_N(VL),
        .C_V_ACT_LINE_N(VACT), .C_V_SYNC_OFS_N(VOFS)
    ) dut (
        .CK_i(clk), .ARST_i(arst), .CK_EE_i(ee), .RST_i(rst),
        .INTERLACE_i(ilace), .BURST_EN_i(ben),
        .HCTRs_o(hctr), .VCTRs_o(vctr), .FCTRs_o(fctr), .FIELD_o(field),
        .XBLK_o(xblk), .XSYNC_o(xsync), .BURST_o(burst), .FRAME_START_o(fstart)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int v; int f;
        bit fld; bit xblk; bit xsync; bit burst; bit fs;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit   sync_map [2][FLEN];
    bit   burst_map [FLEN];

    int   m_pos, m_fctr;
    bit   m_fld, m_mode, m_fs, m_xblk, m_xsync, m_burst;
    bit   cur_il, cur_ben;

    // Paint the expected sync level of every clock of both field types and
    // the burst gate of every clock of a field.
    task automatic paint();
        for (int f = 0; f < 2; f++) begin
            int len;
            len = (f == 1) ? (VL - 1) * N : FLEN;
            for (int i = 0; i < FLEN; i++) sync_map[f][i] = 1'b1;
            for (int ln = 0; ln < len / N; ln++) begin
                for (int pt = 0; pt < 2; pt++) begin
                    int k, w, st;
                    k = -1;
                    for (int kk = 0; kk < 18; kk++) begin
                        int sl, sp;
                        if (f == 0) begin
                            sl = VS + (kk + 1) / 2;
                            sp = kk % 2;
                        end else begin
                            sl = VS + 1 + kk / 2;
                            sp = (kk % 2 == 0) ? 1 : 0;
                        end
                        if (sl == ln && sp == pt) k = kk;
                    end
                    if (k >= 0) w = (k < 6 || k > 11) ? EQ : SLOW;
                    else        w = (pt == 0) ? HSYNC : 0;
                    st = ln * N + ((pt == 0) ? P0 : P1);
                    for (int j = 0; j < w; j++)
                        if (st + j < len) sync_map[f][st + j] = 1'b0;
                end
            end
        end
        for (int i = 0; i < FLEN; i++) burst_map[i] = 1'b0;
        for (int ln = 0; ln < VL; ln++)
            if (!(ln >= VS && ln <= VS + 9))
                for (int j = 0; j < BN; j++) burst_map[ln * N + (BST + j) % N] = 1'b1;
    endtask

    task automatic model_reset();
        m_pos = 0; m_fctr = 0; m_fld = 0; m_mode = 0; m_fs = 0;
        m_xblk = 0; m_xsync = 1; m_burst = 0;
    endtask

    // One enabled clock: outputs take the look-up for the current position,
    // then the raster position advances through the field/frame sequence.
    task automatic model_edge(input bit il, input bit b);
        int h, v, len;
        h = m_pos % N;
        v = m_pos / N;
        m_xblk  = (h < ACT) && (v < VACT);
        m_xsync = sync_map[m_fld][m_pos];
        m_burst = b && burst_map[m_pos];
        len = (m_mode && m_fld) ? (VL - 1) * N : FLEN;
        m_fs = 0;
        if (m_pos + 1 == len) begin
            m_pos = 0;
            if (!m_mode || m_fld) begin
                m_fctr = (m_fctr + 1) % 256;
                m_fs   = 1;
                m_fld  = 0;
                m_mode = il;
            end else begin
                m_fld = 1;
            end
        end else begin
            m_pos++;
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic cycle(input bit a, input bit r, input bit e, input bit il, input bit b);
        exp_t x;
        @(posedge clk);
        #2;
        arst = a; rst = r; ee = e; ilace = il; ben = b;
        if (a || r) model_reset();
        else if (e) model_edge(il, b);
        x.h = m_pos % N; x.v = m_pos / N; x.f = m_fctr; x.fld = m_fld;
        x.xblk = m_xblk; x.xsync = m_xsync; x.burst = m_burst; x.fs = m_fs;
        q.push_back(x);
    endtask

    // Monitor: after every edge compare the DUT against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                vectors++;
                if (int'(hctr) != e.h || int'(vctr) != e.v || int'(fctr) != e.f ||
                    field != e.fld || xblk != e.xblk || xsync != e.xsync ||
                    burst != e.burst || fstart != e.fs) begin
                    miscompares++;
                    $display("FAIL state @%0t: got h=%0d v=%0d f=%0d fld=%0b blk=%0b sync=%0b bst=%0b fs=%0b, want h=%0d v=%0d f=%0d fld=%0b blk=%0b sync=%0b bst=%0b fs=%0b",
                             $time, hctr, vctr, fctr, field, xblk, xsync, burst, fstart,
                             e.h, e.v, e.f, e.fld, e.xblk, e.xsync, e.burst, e.fs);
                end
            end
        end
    end

    initial begin
        arst = 1; rst = 0; ee = 1; ilace = 0; ben = 1;
        cur_il = 0; cur_ben = 1;
        model_reset();
        paint();

        repeat (3) cycle(1, 0, 1, 0, 1);

        // Progressive frames, with a mid-field interlace request withdrawn
        // before the frame end.
        repeat (FLEN + 300) cycle(0, 0, 1, 0, 1);
        repeat (400) cycle(0, 0, 1, 1, 1);
        repeat (FLEN) cycle(0, 0, 1, 0, 1);

        // Interlace for three frames plus the remainder of the current one.
        repeat (3 * (2 * VL - 1) * N + FLEN) cycle(0, 0, 1, 1, 1);

        // Enable held low: everything frozen.
        repeat (50) cycle(0, 0, 0, 1, 1);

        // Burst disabled for a whole frame.
        repeat ((2 * VL - 1) * N + 10) cycle(0, 0, 1, 1, 0);

        // Sync reset at line 5, once with enable high and once with it low.
        for (int i = 0; i < 4000 && (m_pos / N) != 5; i++) cycle(0, 0, 1, 1, 1);
        cycle(0, 1, 1, 1, 1);
        repeat (500) cycle(0, 0, 1, 1, 1);
        cycle(0, 1, 0, 1, 1);
        repeat (20) cycle(0, 0, 1, 1, 1);

        // Randomised enable, mode, burst enable and occasional sync reset.
        cur_il = 1;
        for (int i = 0; i < 12000; i++) begin
            bit e_r, r_r;
            if ($urandom_range(0, 499) == 0) cur_il = !cur_il;
            if ($urandom_range(0, 299) == 0) cur_ben = !cur_ben;
            e_r = ($urandom_range(0, 7) != 0);
            r_r = ($urandom_range(0, 2999) == 0);
            cycle(0, r_r, e_r, cur_il, cur_ben);
        end

        // Asynchronous reset mid-field: state must clear before the next edge.
        for (int i = 0; i < 2000 && (m_pos / N) < 3; i++) cycle(0, 0, 1, 1, 1);
        cycle(1, 0, 0, 1, 1);
        #1;
        vectors++;
        if (hctr != '0 || vctr != '0 || xsync != 1'b1 || xblk != 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got h=%0d v=%0d sync=%0b blk=%0b, want h=0 v=0 sync=1 blk=0",
                     hctr, vctr, xsync, xblk);
        end
        cycle(1, 0, 1, 1, 1);
        repeat (FLEN) cycle(0, 0, 1, 1, 1);

        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_tg_ilace.md
Name: video_tg_ilace

Overview:
Parametrised successor to the square-pixel NTSC timing generator. It adds selectable interlace (525-line, two fields with a half-line vertical offset) and progressive (263-line) operation. In the vertical block it emits true equalising and serration pulses, plus a field ID, a burst gate with enable, and a frame-start strobe. It sits between the pixel clock domain root and the font/pixel composer, and drives the composite sync/blank/burst mixer.

Parameters:
C_H_W, 10, HCTR width
C_V_W, 9, VCTR width
C_H_PX_N, 780, clocks per line (must be even)
C_H_ACT_PX_N, 640, active pixels from HCTR=0
C_HS_START, 659, HCTR of the line-sync falling edge (P0)
C_H_SYNC_N, 58, normal sync low width
C_EQ_N, 29, equalising pulse low width
C_SERR_N, 58, serration high width; serration low width = C_H_PX_N/2 - C_SERR_N
C_BURST_OFS_N, 64, burst start, in clocks after P0
C_BURST_N, 31, burst gate width
C_V_LINE_N, 263, lines per progressive field and per interlace field 0
C_V_ACT_LINE_N, 240, active lines from VCTR=0
C_V_SYNC_OFS_N, 1, lines from end of active to vertical block; VS_LINE = C_V_ACT_LINE_N + C_V_SYNC_OFS_N

Ports:
CK_i  in  1  pixel clock, 12.27272 MHz
ARST_i  in  1  asynchronous reset, active-high
CK_EE_i  in  1  clock enable; all state holds when 0
RST_i  in  1  synchronous reset; same values as ARST_i; wins over CK_EE_i
INTERLACE_i  in  1  mode request: 1 = interlace, 0 = progressive
BURST_EN_i  in  1  burst gate enable
HCTRs_o  out  C_H_W  horizontal counter
VCTRs_o  out  C_V_W  line-in-field counter
FCTRs_o  out  8  frame counter
FIELD_o  out  1  field ID (0/1)
XBLK_o  out  1  1 = active picture
XSYNC_o  out  1  composite sync, low active
BURST_o  out  1  burst gate
FRAME_START_o  out  1  1-cycle strobe

Behaviour:
- Reset values: all counters 0; FIELD 0; mode register 0 (progressive); XBLK_o 0; XSYNC_o 1; BURST_o 0; FRAME_START_o 0.
- Advance: every state change happens only when CK_EE_i=1.
- HCTR: counts 0..C_H_PX_N-1, then wraps to 0.
- VCTR: increments on each HCTR wrap. The field ends at the last line:
  - progressive, or interlace field 0: last line C_V_LINE_N-1;
  - interlace field 1: last line C_V_LINE_N-2.
- Field end: VCTR goes to 0.
  - Interlace: FIELD toggles. Progressive: FIELD stays 0.
- Frame end: end of field 1 (interlace) or every field end (progressive).
  - FCTR increments mod 256.
  - INTERLACE_i is sampled into the mode register.
  - FRAME_START_o pulses during the first cycle of HCTR=0, VCTR=0 of the new frame.
- Mid-frame changes of INTERLACE_i have no effect until the frame end.
- Output timing: XBLK_o, XSYNC_o, BURST_o are registered; each reflects the decode of HCTR/VCTR/FIELD from the previous enabled cycle (1-cycle latency).
- XBLK_o: 1 iff HCTR < C_H_ACT_PX_N and VCTR < C_V_ACT_LINE_N.
- Pulse points: P0 = C_HS_START; P1 = (C_HS_START + C_H_PX_N/2) mod C_H_PX_N.
- Vertical block: 18 consecutive half-line slots, k = 0..17.
  - Field 0: slot k is at line VS_LINE + ceil(k/2); even k at P0, odd k at P1.
  - Field 1: slot k is at line VS_LINE + 1 + floor(k/2); even k at P1, odd k at P0.
  - Slot pulse width: k = 0..5 and 12..17 are equalising, low for C_EQ_N; k = 6..11 are serration, low for C_H_PX_N/2 - C_SERR_N.
- Outside the vertical block: XSYNC low for C_H_SYNC_N starting at P0 only.
- No pulse at P1 outside the block.
- BURST_o: 1 for C_BURST_N clocks starting at (P0 + C_BURST_OFS_N) mod C_H_PX_N. It is forced 0 when:
  - BURST_EN_i=0, or
  - VCTR lies in VS_LINE..VS_LINE+9.
- Internal sync/burst windows are computed modulo C_H_PX_N and wrap across HCTR=0 correctly.
- RST_i or ARST_i mid-field: immediate return to reset values; counting restarts at HCTR=0, VCTR=0, field 0, progressive.

Test Plan:
- Reset, defaults, INTERLACE_i=0 → HCTR period 780, VCTR 0..262. FIELD_o stays 0. FCTRs_o +1 every 263 lines. FRAME_START_o is 1 cycle per 205140 clocks.
- Line 10 → XBLK_o high for 640 clocks from one cycle after HCTR=0. XSYNC_o low during 58 clocks, registered from HCTR 659..716. BURST_o high, registered from HCTR 723..753.
- Progressive vertical block → XSYNC_o lows:
  - 29-clock pulses at 241@659, 242@269, 242@659 and onward;
  - 332-clock serration lows for slots 6..11;
  - no burst on lines 241..250.
- INTERLACE_i=1, held for 3 frames → fields alternate 263/262 lines and FIELD_o toggles. FCTRs_o +1 per 525 lines. The field-1 block starts at 242@269, half a line later than the field-0 block.
- INTERLACE_i toggled mid field 0 → no change until the frame end; the mode switch takes effect at the next FRAME_START_o.
- CK_EE_i held at 0 for 50 cycles → all outputs frozen. BURST_EN_i=0 → BURST_o is 0 on every line. RST_i pulsed at VCTR=100 → counters 0, XSYNC_o=1 on the next cycle.
